icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Miss/refill sequencer for the fetch-stage instruction cache (direct-mapped tag array plus byte-organised data array). On a fetch miss it freezes the PC and IF/ID registers, reads the missing line from instruction memory one 32-bit word at a time over a req/ack handshake, writes the words into the data array and the tag into the tag array, then releases the pipeline. It sits between the fetch stage, the cache arrays and the memory port, and is the sole driver of pc_we and IFID_we during misses.

Parameters:
TAG_W, 22, tag width stored per line
INDEX_W, 7, line index bits
WORDS_PER_LINE, 2, 32-bit words per line (8 bytes); power of two, >=1
OFFS_W, derived: log2(WORDS_PER_LINE)+2, byte-offset bits; TAG_W+INDEX_W+OFFS_W must equal 32

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_valid  in  1  fetch stage presents a valid PC this cycle
fetch_addr  in  32  current PC
tag_hit  in  1  tag match and valid for fetch_addr's line (combinational from tag array)
pc_we  out  1  PC write enable
IFID_we  out  1  IF/ID register write enable
mem_req  out  1  memory read request
mem_addr  out  32  word-aligned read address
mem_ack  in  1  mem_rdata valid; completes current beat
mem_rdata  in  32  read data
data_we  out  1  write one word into data array
data_index  out  INDEX_W  line being written
data_word  out  log2(WORDS_PER_LINE) (min 1)  word within line
data_wdata  out  32  word to write (big-endian bytes: [31:24] to byte 0)
tag_we  out  1  write tag and set valid
tag_index  out  INDEX_W  line index for tag write
tag_wdata  out  TAG_W  tag value
miss_count  out  16  saturating count of misses serviced
busy  out  1  refill in progress (state != IDLE)

Behaviour:
- Reset (synchronous, active-high) and clk: all sequential state is updated on the rising edge of clk. Reset forces state IDLE, beat=0, miss_count=0, and the latched line address to 0. All strobes (mem_req, data_we, tag_we) read 0 after reset. Outputs pc_we and IFID_we then follow the IDLE rule.
- States: IDLE, FILL, TAG, RESUME.
- IDLE:
  - pc_we = IFID_we = !(fetch_valid && !tag_hit). This is combinational: a stall is asserted in the same cycle the miss is seen.
  - On a miss, latch {tag, index} from fetch_addr[31:OFFS_W], set beat=0, and go to FILL.
- FILL:
  - mem_req=1; mem_addr = {latched tag, latched index, beat, 2'b00}.
  - Request, address and beat hold stable until mem_ack. Zero wait states are allowed (ack in the first FILL cycle).
  - In a cycle with mem_ack=1: data_we=1, data_index=latched index, data_word=beat, data_wdata=mem_rdata.
  - If beat==WORDS_PER_LINE-1, go to TAG; otherwise beat++.
  - mem_ack is ignored outside FILL.
- TAG: tag_we=1, tag_index and tag_wdata from the latch; miss_count++ (saturates at 16'hFFFF). Next state RESUME.
- RESUME: one stall cycle so the arrays re-read the now-valid line. Next state IDLE.
- pc_we = IFID_we = 0 in FILL, TAG and RESUME. Line fill latency with zero-wait memory is WORDS_PER_LINE+2 stall cycles, plus the IDLE miss cycle.
- The tag is written only after all words are written; a partially filled line is never marked valid.
- fetch_addr and fetch_valid changes during a refill are ignored; the latched line is completed.
- Reset during FILL/TAG aborts immediately: no further data_we or tag_we, and the line stays invalid unless its tag was already written.
- A miss in the cycle RESUME→IDLE is evaluated normally in IDLE (back-to-back misses are allowed).
- busy = (state != IDLE).

Decomposition:
- Shared package mips_cache_pkg holds:
  - TAG_W, INDEX_W and WORDS_PER_LINE defaults
  - the state enum (IDLE/FILL/TAG/RESUME)
  - address-slicing helpers for tag, index, word and byte
- No sub-module is needed. The saturating counter is one always block; it may be split into sat_counter if reused by a future D-cache controller.

Test Plan:
- Hit path: tag_hit=1, fetch_valid=1 at PC 0 → pc_we=IFID_we=1 every cycle; mem_req never asserted; miss_count=0.
- Zero-wait miss: PC=32'h0000_0040, tag_hit=0, mem_ack tied 1, mem_rdata 32'h0FF03C83 then 32'hFF00FC03. Required response:
  - mem_addr 0x40 then 0x44
  - data_we on index 8, words 0 then 1, with those values
  - tag_we in the next cycle (tag 0, index 8)
  - stall lasts exactly 5 cycles; miss_count=1
- Wait states: same miss, ack after 3 cycles per beat → mem_req and mem_addr stay stable while waiting; exactly 2 data_we pulses; stall lasts 9 cycles.
- PC change mid-refill: fetch_addr switched to 32'h100 during FILL → the refill still writes index 8 with tag 0; no request for 0x100 until back in IDLE.
- Reset during beat 1 → no tag_we; busy=0, mem_req=0 the cycle after reset; miss_count=0.
- Saturation: force 65536 misses (or preload the counter via hierarchical force) → miss_count holds 16'hFFFF.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cache_pkg
//  Description : Shared widths, refill state encoding and address-slicing
//                helpers for the instruction-cache refill controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_cache_pkg;

    // Default cache geometry: 22-bit tag, 128 lines, two 32-bit words per line
    localparam int c_TAG_W          = 22;
    localparam int c_INDEX_W        = 7;
    localparam int c_WORDS_PER_LINE = 2;

    // Refill sequencer state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_FILL   = 2'd1;
    localparam state_t c_ST_TAG    = 2'd2;
    localparam state_t c_ST_RESUME = 2'd3;

    // Byte-offset bits within a line (word select plus byte-in-word)
    function automatic int offs_w(input int wpl);
        return $clog2(wpl) + 2;
    endfunction

    // Width of the word-within-line select; never narrower than one bit
    function automatic int word_sel_w(input int wpl);
        return (wpl > 1) ? $clog2(wpl) : 1;
    endfunction

    // Tag field, right-justified; caller truncates to the tag width
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int tag_lsb);
        return addr >> tag_lsb;
    endfunction

    // Line index field, right-justified; caller truncates to the index width
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int offs);
        return addr >> offs;
    endfunction

    // Word address (word-within-line in the low bits); caller truncates
    function automatic logic [31:0] addr_word(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    // Byte within a 32-bit word
    function automatic logic [1:0] addr_byte(input logic [31:0] addr);
        return addr[1:0];
    endfunction

endpackage : mips_cache_pkg
`default_nettype wire

// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl_if
//  Description : Fetch-stage, memory-port and cache-array signals seen by the
//                instruction-cache refill controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface icache_refill_ctrl_if
    import mips_cache_pkg::*;
#(
    parameter int TAG_W      = c_TAG_W,
    parameter int INDEX_W    = c_INDEX_W,
    parameter int WORD_SEL_W = word_sel_w(c_WORDS_PER_LINE)
);

    // Fetch stage
    logic                  fetch_valid;
    logic [31:0]           fetch_addr;
    logic                  tag_hit;
    logic                  pc_we;
    logic                  IFID_we;

    // Instruction memory port
    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    // Cache array write ports
    logic                  data_we;
    logic [INDEX_W-1:0]    data_index;
    logic [WORD_SEL_W-1:0] data_word;
    logic [31:0]           data_wdata;
    logic                  tag_we;
    logic [INDEX_W-1:0]    tag_index;
    logic [TAG_W-1:0]      tag_wdata;

    // Status
    logic [15:0]           miss_count;
    logic                  busy;

    // Controller side
    modport master (
        input  fetch_valid, fetch_addr, tag_hit, mem_ack, mem_rdata,
        output pc_we, IFID_we, mem_req, mem_addr,
        output data_we, data_index, data_word, data_wdata,
        output tag_we, tag_index, tag_wdata, miss_count, busy
    );

    // Pipeline / memory / array side
    modport slave (
        output fetch_valid, fetch_addr, tag_hit, mem_ack, mem_rdata,
        input  pc_we, IFID_we, mem_req, mem_addr,
        input  data_we, data_index, data_word, data_wdata,
        input  tag_we, tag_index, tag_wdata, miss_count, busy
    );

endinterface : icache_refill_ctrl_if
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl
//  Description : Instruction-cache miss/refill sequencer. Stalls the PC and
//                IF/ID registers on a fetch miss, reads the line one word per
//                beat over a req/ack port, writes the data array, then the
//                tag, and releases the pipeline after one re-read cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
    import mips_cache_pkg::*;
#(
    parameter int TAG_W          = c_TAG_W,
    parameter int INDEX_W        = c_INDEX_W,
    parameter int WORDS_PER_LINE = c_WORDS_PER_LINE
) (
    input  logic                 clk,
    input  logic                 reset,
    icache_refill_ctrl_if.master bus
);

    localparam int c_OFFS_W = offs_w(WORDS_PER_LINE);
    localparam int c_WSEL_W = word_sel_w(WORDS_PER_LINE);
    localparam logic [c_WSEL_W-1:0] c_LAST_BEAT = c_WSEL_W'(WORDS_PER_LINE - 1);
    localparam logic [c_WSEL_W-1:0] c_BEAT_ONE  = c_WSEL_W'(1);

    state_t              r_state;
    logic [c_WSEL_W-1:0] r_beat;
    logic [TAG_W-1:0]    r_tag;
    logic [INDEX_W-1:0]  r_index;
    logic                r_mem_req;
    logic                r_tag_we;
    logic [15:0]         r_miss_count;

    logic                w_idle;
    logic                w_miss;
    logic                w_beat_done;
    logic [31:0]         w_mem_addr;

    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_miss      = bus.fetch_valid && !bus.tag_hit;
    assign w_beat_done = (r_state == c_ST_FILL) && bus.mem_ack;

    // Beat address: latched line plus the word select (absent for 1-word lines)
    if (WORDS_PER_LINE > 1) begin : g_multi_word
        assign w_mem_addr = {r_tag, r_index, r_beat, 2'b00};
    end else begin : g_single_word
        assign w_mem_addr = {r_tag, r_index, 2'b00};
    end

    // Refill sequencer: latch the missing line, step beats on ack, write tag last
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_beat    <= '0;
            r_tag     <= '0;
            r_index   <= '0;
            r_mem_req <= 1'b0;
            r_tag_we  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_miss) begin
                        r_tag     <= TAG_W'(addr_tag(bus.fetch_addr, c_OFFS_W + INDEX_W));
                        r_index   <= INDEX_W'(addr_index(bus.fetch_addr, c_OFFS_W));
                        r_beat    <= '0;
                        r_mem_req <= 1'b1;
                        r_state   <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    if (bus.mem_ack) begin
                        if (r_beat == c_LAST_BEAT) begin
                            // Whole line is in the data array; only now mark it valid
                            r_mem_req <= 1'b0;
                            r_tag_we  <= 1'b1;
                            r_state   <= c_ST_TAG;
                        end else begin
                            r_beat <= r_beat + c_BEAT_ONE;
                        end
                    end
                end
                c_ST_TAG: begin
                    r_tag_we <= 1'b0;
                    r_state  <= c_ST_RESUME;
                end
                c_ST_RESUME: begin
                    // Arrays re-read the freshly valid line this cycle
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_tag_we  <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Serviced-miss counter, bumped once per tag write and pinned at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_miss_count <= '0;
        end else if ((r_state == c_ST_TAG) && (r_miss_count != 16'hFFFF)) begin
            r_miss_count <= r_miss_count + 16'd1;
        end
    end

    // Stall is combinational in IDLE so the miss cycle itself holds the PC
    assign bus.pc_we      = w_idle && !w_miss;
    assign bus.IFID_we    = w_idle && !w_miss;

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = w_mem_addr;

    // Array strobes are masked by reset so an abort writes nothing further
    assign bus.data_we    = w_beat_done && !reset;
    assign bus.data_index = r_index;
    assign bus.data_word  = r_beat;
    assign bus.data_wdata = bus.mem_rdata;

    assign bus.tag_we     = r_tag_we && !reset;
    assign bus.tag_index  = r_index;
    assign bus.tag_wdata  = r_tag;

    assign bus.miss_count = r_miss_count;
    assign bus.busy       = !w_idle;

endmodule : icache_refill_ctrl
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_ctrl
//  Description : Self-checking bench for the instruction-cache refill
//                controller: vector table, directed refill sequences and a
//                randomized run against a line-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;
    import mips_cache_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    icache_refill_ctrl_if #(.TAG_W(22), .INDEX_W(7), .WORD_SEL_W(1)) bus ();

    icache_refill_ctrl #(
        .TAG_W          (22),
        .INDEX_W        (7),
        .WORDS_PER_LINE (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rd_words [2];

    typedef struct {
        logic        fv;
        logic        hit;
        logic [31:0] addr;
        logic        exp_stall;
    } vec_t;

    vec_t vt [6];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.fetch_valid = 1'b0;
        bus.tag_hit     = 1'b1;
        bus.fetch_addr  = 32'h0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 32'h0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One complete miss on pc with ack arriving after dly waiting cycles per beat
    task automatic run_miss(input logic [31:0] pc, input int dly, input bit switch_pc,
                            input int exp_stall, input logic [15:0] exp_count);
        int stall = 0;
        int nwr = 0;
        int ntag = 0;
        int wait_ctr = 0;
        int beat = 0;
        bit done = 0;
        logic [31:0] base;
        logic [6:0]  e_idx;
        logic [21:0] e_tag;
        base  = {pc[31:3], 3'b000};
        e_idx = pc[9:3];
        e_tag = pc[31:10];
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.fetch_valid = 1'b1;
                bus.tag_hit     = 1'b0;
                bus.fetch_addr  = pc;
            end else if (switch_pc) begin
                bus.fetch_addr = 32'h100;
            end
            if (ntag > 0) bus.tag_hit = 1'b1;
            bus.mem_ack   = bus.mem_req && (wait_ctr == dly);
            bus.mem_rdata = (beat < 2) ? rd_words[beat] : 32'h0;
            @(negedge clk);
            if (!bus.pc_we) stall++;
            if (bus.mem_req) begin
                check_eq("mem_addr", bus.mem_addr, base + 32'(4 * beat));
                wait_ctr++;
            end
            if (bus.data_we) begin
                check_eq("data_index", bus.data_index, e_idx);
                check_eq("data_word", bus.data_word, beat[0]);
                check_eq("data_wdata", bus.data_wdata, rd_words[beat < 2 ? beat : 0]);
                beat++;
                nwr++;
                wait_ctr = 0;
            end
            if (bus.tag_we) begin
                check_eq("tag_index", bus.tag_index, e_idx);
                check_eq("tag_wdata", bus.tag_wdata, e_tag);
                check_eq("tag_after_fill", nwr, 2);
                ntag++;
            end
            if (c > 0 && bus.pc_we) done = 1;
        end
        bus.mem_ack = 1'b0;
        check_eq("refill_completes", done, 1);
        check_eq("stall_cycles", stall, exp_stall);
        check_eq("data_we_pulses", nwr, 2);
        check_eq("tag_we_pulses", ntag, 1);
        check_eq("miss_count", bus.miss_count, exp_count);
        // Back in IDLE with a hit: no further request, e.g. for a switched PC
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("idle_no_req", {bus.mem_req, bus.busy, bus.pc_we}, 3'b001);
        end
    endtask

    // Line-level reference model state
    int          m_words_left;
    int          m_post;
    logic [28:0] m_line;
    logic [15:0] m_misses;

    initial begin
        int ntag_seen;
        reset = 1'b1;
        idle_inputs();
        rd_words[0] = 32'h0FF03C83;
        rd_words[1] = 32'hFF00FC03;

        vt[0] = '{fv: 1'b0, hit: 1'b0, addr: 32'h0000_0040, exp_stall: 1'b0};
        vt[1] = '{fv: 1'b0, hit: 1'b1, addr: 32'h1234_5678, exp_stall: 1'b0};
        vt[2] = '{fv: 1'b1, hit: 1'b1, addr: 32'h0000_0000, exp_stall: 1'b0};
        vt[3] = '{fv: 1'b1, hit: 1'b1, addr: 32'hDEAD_BEEC, exp_stall: 1'b0};
        vt[4] = '{fv: 1'b0, hit: 1'b0, addr: 32'hFFFF_FFFC, exp_stall: 1'b0};
        vt[5] = '{fv: 1'b1, hit: 1'b0, addr: 32'h0000_0200, exp_stall: 1'b1};

        // Reset state; ack is raised to show it is ignored in IDLE
        do_reset();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        check_eq("reset_strobes", {bus.mem_req, bus.data_we, bus.tag_we, bus.busy}, 4'b0000);
        check_eq("reset_count", bus.miss_count, 16'h0);
        check_eq("reset_pc_we", {bus.pc_we, bus.IFID_we}, 2'b11);
        bus.mem_ack = 1'b0;

        // Vector table in IDLE
        foreach (vt[i]) begin
            @(posedge clk); #1;
            bus.fetch_valid = vt[i].fv;
            bus.tag_hit     = vt[i].hit;
            bus.fetch_addr  = vt[i].addr;
            @(negedge clk);
            check_eq("vec_stall", {bus.pc_we, bus.IFID_we}, {2{!vt[i].exp_stall}});
            check_eq("vec_idle", {bus.mem_req, bus.busy}, 2'b00);
            if (vt[i].exp_stall) begin
                bit drained = 0;
                for (int c = 0; c < 20 && !drained; c++) begin
                    @(posedge clk); #1;
                    bus.tag_hit = 1'b1;
                    bus.mem_ack = 1'b1;
                    @(negedge clk);
                    if (!bus.busy) drained = 1;
                end
                bus.mem_ack = 1'b0;
                check_eq("vec_drain", drained, 1);
                check_eq("vec_count", bus.miss_count, 16'h1);
            end
        end

        // Hit path at PC 0
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            bus.fetch_valid = 1'b1;
            bus.tag_hit     = 1'b1;
            bus.fetch_addr  = 32'h0;
            @(negedge clk);
            check_eq("hit_path", {bus.pc_we, bus.IFID_we, bus.mem_req}, 3'b110);
        end
        check_eq("hit_count", bus.miss_count, 16'h0);

        // Zero-wait, wait-state and PC-switch refills of line 0x40
        do_reset();
        run_miss(32'h0000_0040, 0, 1'b0, 5, 16'd1);
        do_reset();
        run_miss(32'h0000_0040, 2, 1'b0, 9, 16'd1);
        do_reset();
        run_miss(32'h0000_0040, 1, 1'b1, 7, 16'd1);
        run_miss(32'h0000_0044, 0, 1'b0, 5, 16'd2);

        // Reset while waiting on beat 1
        do_reset();
        @(posedge clk); #1;
        bus.fetch_valid = 1'b1; bus.tag_hit = 1'b0; bus.fetch_addr = 32'h40;
        @(posedge clk); #1;
        bus.mem_ack = 1'b1; bus.mem_rdata = rd_words[0];
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check_eq("rst_beat1_req", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h44});
        @(posedge clk); #1;
        reset = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = rd_words[1];
        @(negedge clk);
        check_eq("rst_abort_strobes", {bus.data_we, bus.tag_we}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0; bus.mem_ack = 1'b0; bus.tag_hit = 1'b1;
        @(negedge clk);
        check_eq("rst_after", {bus.busy, bus.mem_req, bus.pc_we}, 3'b001);
        check_eq("rst_count", bus.miss_count, 16'h0);
        ntag_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.tag_we) ntag_seen++;
        end
        check_eq("rst_no_tag", ntag_seen, 0);

        // Saturation via preloaded counter
        do_reset();
        force dut.r_miss_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.r_miss_count;
        @(negedge clk);
        check_eq("sat_preload", bus.miss_count, 16'hFFFE);
        run_miss(32'h0000_0040, 0, 1'b0, 5, 16'hFFFF);
        run_miss(32'h0000_0048, 0, 1'b0, 5, 16'hFFFF);

        // Randomized run against the line-level model
        do_reset();
        m_words_left = 0; m_post = 0; m_line = '0; m_misses = '0;
        for (int c = 0; c < 3000; c++) begin
            bit          idle, e_pc, e_req, e_dwe, e_twe;
            logic [31:0] e_addr;
            @(posedge clk); #1;
            reset           = ($urandom_range(0, 99) == 0);
            bus.fetch_valid = ($urandom_range(0, 4) != 0);
            bus.tag_hit     = $urandom_range(0, 1) == 1;
            bus.fetch_addr  = $urandom;
            bus.mem_ack     = $urandom_range(0, 1) == 1;
            bus.mem_rdata   = $urandom;
            idle   = (m_words_left == 0) && (m_post == 0);
            e_pc   = idle && !(bus.fetch_valid && !bus.tag_hit);
            e_req  = (m_words_left > 0);
            e_addr = {m_line, 3'b000} + 32'(4 * (2 - m_words_left));
            e_dwe  = e_req && bus.mem_ack && !reset;
            e_twe  = (m_post == 2) && !reset;
            @(negedge clk);
            check_eq("rand_ctrl", {bus.pc_we, bus.IFID_we, bus.mem_req, bus.data_we, bus.tag_we, bus.busy},
                     {e_pc, e_pc, e_req, e_dwe, e_twe, !idle});
            check_eq("rand_count", bus.miss_count, m_misses);
            if (e_req) check_eq("rand_mem_addr", bus.mem_addr, e_addr);
            if (e_dwe) check_eq("rand_data", {bus.data_index, bus.data_word, bus.data_wdata},
                                {m_line[6:0], 1'(2 - m_words_left), bus.mem_rdata});
            if (e_twe) check_eq("rand_tag", {bus.tag_index, bus.tag_wdata}, {m_line[6:0], m_line[28:7]});
            if (reset) begin
                m_words_left = 0; m_post = 0; m_line = '0; m_misses = '0;
            end else if (idle) begin
                if (bus.fetch_valid && !bus.tag_hit) begin
                    m_line       = bus.fetch_addr[31:3];
                    m_words_left = 2;
                end
            end else if (m_words_left > 0) begin
                if (bus.mem_ack) begin
                    m_words_left--;
                    if (m_words_left == 0) m_post = 2;
                end
            end else begin
                if (m_post == 2 && m_misses != 16'hFFFF) m_misses++;
                m_post--;
            end
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_icache_refill_ctrl
`default_nettype wire
